// File: rtl/bmi_bitscan_ctrl.sv
// Bit-serial scan controller for the BMI 16:1 bit-select mux: POPCNT/TZCNT/LZCNT/PARITY.
// Define BITSCAN_EARLY_EXIT_EN to let TZCNT/LZCNT stop at the first 1-bit.
module bmi_bitscan_ctrl #(
    parameter int N_BITS = 16,
    parameter int RES_W  = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [1:0]                op_i,
    input  logic                      mux_out_i,
    output logic [$clog2(N_BITS)-1:0] sel_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [RES_W-1:0]          result_o,
    output logic                      zero_flag_o,
    output logic                      src_zero_o
);

    localparam int SEL_W = $clog2(N_BITS);

    localparam logic [1:0] OP_POPCNT = 2'b00;
    localparam logic [1:0] OP_TZCNT  = 2'b01;
    localparam logic [1:0] OP_LZCNT  = 2'b10;
    localparam logic [1:0] OP_PARITY = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [4:0]         step_q, step_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic               found_q, found_d;
    logic               srcz_q, srcz_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               src_zero_q, src_zero_d;

    logic [RES_W-1:0]   acc_next;
    logic               exit_now;

    // Accumulator value after absorbing the bit currently returned by the mux.
    always_comb begin
        acc_next = acc_q;
        case (op_q)
            OP_POPCNT: acc_next = acc_q + RES_W'(mux_out_i);
            OP_PARITY: acc_next = RES_W'(acc_q[0] ^ mux_out_i);
            default:   acc_next = (found_q || mux_out_i) ? acc_q : acc_q + RES_W'(1);
        endcase
    end

`ifdef BITSCAN_EARLY_EXIT_EN
    assign exit_now = ((op_q == OP_TZCNT) || (op_q == OP_LZCNT)) && mux_out_i;
`else
    assign exit_now = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        step_d     = step_q;
        acc_d      = acc_q;
        found_d    = found_q;
        srcz_d     = srcz_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        src_zero_d = src_zero_q;

        case (state_q)
            IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (start_i) begin
                    state_d = SCAN;
                    op_d    = op_i;
                    step_d  = '0;
                    acc_d   = '0;
                    found_d = 1'b0;
                    srcz_d  = 1'b1;
                    busy_d  = 1'b1;
                    sel_d   = (op_i == OP_LZCNT) ? SEL_W'(N_BITS - 1) : '0;
                end
            end
            SCAN: begin
                acc_d   = acc_next;
                found_d = found_q | mux_out_i;
                srcz_d  = srcz_q & ~mux_out_i;
                step_d  = step_q + 5'd1;
                if ((step_q == 5'(N_BITS - 1)) || exit_now) begin
                    state_d    = DONE;
                    sel_d      = '0;
                    done_d     = 1'b1;
                    result_d   = acc_next;
                    zero_d     = (acc_next == '0);
                    src_zero_d = srcz_q & ~mux_out_i;
                end else if (op_q == OP_LZCNT) begin
                    sel_d = sel_q - SEL_W'(1);
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset clears the published result to 0, which is why zero_flag resets high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= OP_POPCNT;
            step_q     <= '0;
            acc_q      <= '0;
            found_q    <= 1'b0;
            srcz_q     <= 1'b0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            src_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            found_q    <= found_d;
            srcz_q     <= srcz_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            src_zero_q <= src_zero_d;
        end
    end

    assign sel_o       = sel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign zero_flag_o = zero_q;
    assign src_zero_o  = src_zero_q;

endmodule
